// File: rtl/store_packer.sv
// Store-side data-bus master: packs SB/SH/SW data into byte lanes and runs one write on the req/addr_ok/data_ok bus.
// Optional SWL/SWR support is compiled in when UNALIGNED_STORE_EN is defined.
module store_packer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [2:0]        st_op,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic              st_flush,
  output logic              st_stall,
  output logic              st_ades,
  output logic [ADDR_W-1:0] st_badvaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_req;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_wdata;

  logic              w_sb, w_sh, w_sw, w_legal, w_ades, w_accept;
  logic [1:0]        w_lo;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;

  assign w_lo = st_addr[1:0];
  assign w_sb = (st_op == 3'b000);
  assign w_sh = (st_op == 3'b001);
  assign w_sw = (st_op == 3'b010);

`ifdef UNALIGNED_STORE_EN
  logic w_swl, w_swr;
  assign w_swl   = (st_op == 3'b100);
  assign w_swr   = (st_op == 3'b101);
  assign w_legal = w_sb | w_sh | w_sw | w_swl | w_swr;
`else
  assign w_legal = w_sb | w_sh | w_sw;
`endif

  assign w_ades      = st_valid & ((w_sh & w_lo[0]) | (w_sw & (w_lo != 2'b00)));
  assign w_accept    = st_valid & w_legal & ~w_ades & ~st_flush;
  assign st_ades     = w_ades;
  assign st_badvaddr = w_ades ? st_addr : '0;

  always_comb begin
    w_size  = 2'd2;
    w_addr  = st_addr;
    w_wstrb = 4'b1111;
    w_wdata = st_data;
    if (w_sb) begin
      w_size  = 2'd0;
      w_wstrb = 4'b0001 << w_lo;
      w_wdata = {4{st_data[7:0]}};
    end else if (w_sh) begin
      w_size  = 2'd1;
      w_wstrb = w_lo[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{st_data[15:0]}};
    end
`ifdef UNALIGNED_STORE_EN
    // SWL writes the high bytes of rt into the low end of the word; SWR the reverse.
    else if (w_swl) begin
      w_addr = {st_addr[ADDR_W-1:2], 2'b00};
      case (w_lo)
        2'd0:    begin w_wstrb = 4'b0001; w_wdata = {24'b0, st_data[31:24]}; end
        2'd1:    begin w_wstrb = 4'b0011; w_wdata = {16'b0, st_data[31:16]}; end
        2'd2:    begin w_wstrb = 4'b0111; w_wdata = {8'b0, st_data[31:8]};   end
        default: begin w_wstrb = 4'b1111; w_wdata = st_data;                 end
      endcase
    end else if (w_swr) begin
      w_addr = {st_addr[ADDR_W-1:2], 2'b00};
      case (w_lo)
        2'd0:    begin w_wstrb = 4'b1111; w_wdata = st_data;                 end
        2'd1:    begin w_wstrb = 4'b1110; w_wdata = {st_data[23:0], 8'b0};   end
        2'd2:    begin w_wstrb = 4'b1100; w_wdata = {st_data[15:0], 16'b0};  end
        default: begin w_wstrb = 4'b1000; w_wdata = {st_data[7:0], 24'b0};   end
      endcase
    end
`endif
  end

  always_comb begin
    w_next   = r_state;
    st_stall = 1'b0;
    case (r_state)
      IDLE: begin
        st_stall = w_accept;
        if (w_accept) w_next = REQ;
      end
      REQ: begin
        // addr_ok outranks flush: once accepted by the bus the write must finish.
        if (data_addr_ok) begin
          st_stall = ~data_data_ok;
          w_next   = data_data_ok ? IDLE : WAIT;
        end else if (st_flush) begin
          w_next = IDLE;
        end else begin
          st_stall = 1'b1;
        end
      end
      WAIT: begin
        st_stall = ~data_data_ok;
        if (data_data_ok) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_req   <= (w_next == REQ);
      r_wr    <= (w_next == REQ);
      if ((r_state == IDLE) && w_accept) begin
        r_size  <= w_size;
        r_addr  <= w_addr;
        r_wstrb <= w_wstrb;
        r_wdata <= w_wdata;
      end
    end
  end

  assign data_req   = r_req;
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wstrb = r_wstrb;
  assign data_wdata = r_wdata;

endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer with a transaction-level reference model compared every cycle.
// Covers both builds; the unaligned section follows UNALIGNED_STORE_EN.
module tb_store_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [2:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_flush;
  logic        st_stall;
  logic        st_ades;
  logic [31:0] st_badvaddr;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  store_packer #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_flush(st_flush), .st_stall(st_stall), .st_ades(st_ades), .st_badvaddr(st_badvaddr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding write described as "requested" or "awaiting completion".
  bit          m_live = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_wait = 1'b0;
  logic [1:0]  m_size = '0;
  logic [31:0] m_addr = '0;
  logic [3:0]  m_strb = '0;
  logic [31:0] m_wdata = '0;
  int          log_cnt = 0;
  logic [31:0] log_addr = '0;
  logic [3:0]  log_strb = '0;
  logic [31:0] log_wdata = '0;
  logic [1:0]  log_size = '0;

  bit          c_idle, c_acc, c_stall, c_ades;
  logic [1:0]  p_size;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_strb;

  function automatic bit is_legal(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010: return 1'b1;
`ifdef UNALIGNED_STORE_EN
      3'b100, 3'b101: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit mdl_ades(input logic v, input logic [2:0] op, input logic [31:0] a);
    return v && ((op == 3'b001 && (a % 2) != 0) || (op == 3'b010 && (a % 4) != 0));
  endfunction

  task automatic pack(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                      output logic [1:0] size, output logic [31:0] ba,
                      output logic [3:0] strb, output logic [31:0] wd);
    int unsigned lane;
    int unsigned n;
    lane = a % 4;
    size = 2'd2; ba = a; strb = 4'hF; wd = d;
    case (op)
      3'b000: begin size = 2'd0; strb = 4'(1 << lane); wd = {24'b0, d[7:0]} * 32'h01010101; end
      3'b001: begin size = 2'd1; strb = 4'(3 << (lane & 2)); wd = {16'b0, d[15:0]} * 32'h00010001; end
      3'b100: begin n = lane + 1; ba = a - lane; strb = 4'((1 << n) - 1); wd = d >> (8 * (4 - n)); end
      3'b101: begin ba = a - lane; strb = 4'((15 << lane) & 15); wd = d << (8 * lane); end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      c_idle  = !m_pend && !m_wait;
      c_ades  = mdl_ades(st_valid, st_op, st_addr);
      c_acc   = c_idle && st_valid && is_legal(st_op) && !c_ades && !st_flush;
      if (c_idle)      c_stall = c_acc;
      else if (m_pend) c_stall = data_addr_ok ? !data_data_ok : !st_flush;
      else             c_stall = !data_data_ok;
      if (m_live && !rst) begin
        chk("m_stall", st_stall, c_stall);
        chk("m_ades", st_ades, c_ades);
        chk("m_badvaddr", st_badvaddr, c_ades ? st_addr : 32'h0);
        chk("m_req", data_req, m_pend);
        chk("m_wr", data_wr, m_pend);
        chk("m_size", data_size, m_size);
        chk("m_addr", data_addr, m_addr);
        chk("m_wstrb", data_wstrb, m_strb);
        chk("m_wdata", data_wdata, m_wdata);
      end
      if (rst) begin
        m_live = 1'b1; m_pend = 1'b0; m_wait = 1'b0;
        m_size = '0; m_addr = '0; m_strb = '0; m_wdata = '0;
      end else if (c_idle) begin
        if (c_acc) begin
          pack(st_op, st_addr, st_data, p_size, p_addr, p_strb, p_wdata);
          m_pend = 1'b1; m_size = p_size; m_addr = p_addr; m_strb = p_strb; m_wdata = p_wdata;
        end
      end else if (m_pend) begin
        if (data_addr_ok) begin
          log_cnt++; log_addr = m_addr; log_strb = m_strb; log_wdata = m_wdata; log_size = m_size;
          m_pend = 1'b0; m_wait = !data_data_ok;
        end else if (st_flush) begin
          m_pend = 1'b0;
        end
      end else if (data_data_ok) begin
        m_wait = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic fl, input logic aok, input logic dok);
    st_valid = v; st_op = op; st_addr = a; st_data = d;
    st_flush = fl; data_addr_ok = aok; data_data_ok = dok;
  endtask

  task automatic quiet();
    set_in(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    quiet();
    tick(); tick();
    chk("rst_req", data_req, 0);
    chk("rst_wr", data_wr, 0);
    chk("rst_size", data_size, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_wstrb", data_wstrb, 0);
    chk("rst_wdata", data_wdata, 0);
    chk("rst_stall", st_stall, 0);
    rst = 1'b0;
    tick();

    // SB 0x1003, immediate addr_ok+data_ok
    set_in(1, 3'b000, 32'h1003, 32'h123456AB, 0, 0, 0); #1;
    chk("sb_acc_stall", st_stall, 1);
    tick();
    chk("sb_req", data_req, 1);
    chk("sb_wstrb", data_wstrb, 4'b1000);
    chk("sb_wdata", data_wdata, 32'hABABABAB);
    chk("sb_size", data_size, 0);
    set_in(1, 3'b000, 32'h1003, 32'h123456AB, 0, 1, 1); #1;
    chk("sb_done_stall", st_stall, 0);
    tick();
    quiet(); #1;
    chk("sb_req_drop", data_req, 0);
    chk("sb_log_cnt", log_cnt, 1);
    chk("sb_log_wdata", log_wdata, 32'hABABABAB);
    chk("sb_log_wstrb", log_strb, 4'b1000);
    tick();

    // SH misaligned
    set_in(1, 3'b001, 32'h2001, 32'h00001111, 0, 0, 0); #1;
    chk("ades_flag", st_ades, 1);
    chk("ades_bad", st_badvaddr, 32'h2001);
    chk("ades_stall", st_stall, 0);
    tick();
    chk("ades_noreq", data_req, 0);
    quiet(); tick();

    // SW with delayed addr_ok; stray data_ok during REQ ignored
    set_in(1, 3'b010, 32'h3000, 32'hDEADBEEF, 0, 0, 0); tick();
    chk("sw_req1", data_req, 1);
    set_in(1, 3'b010, 32'h3000, 32'hDEADBEEF, 0, 0, 1); #1;
    chk("sw_stray_dok_stall", st_stall, 1);
    tick();
    set_in(1, 3'b010, 32'h3000, 32'hDEADBEEF, 0, 0, 0); tick();
    set_in(1, 3'b010, 32'h3000, 32'hDEADBEEF, 0, 1, 0); #1;
    chk("sw_aok_stall", st_stall, 1);
    chk("sw_wstrb", data_wstrb, 4'b1111);
    chk("sw_wdata", data_wdata, 32'hDEADBEEF);
    tick();
    chk("sw_wait_noreq", data_req, 0);
    set_in(1, 3'b010, 32'h3000, 32'hDEADBEEF, 0, 0, 0); tick();
    set_in(1, 3'b010, 32'h3000, 32'hDEADBEEF, 0, 0, 1); #1;
    chk("sw_dok_stall", st_stall, 0);
    tick();
    quiet(); #1;
    chk("sw_log_cnt", log_cnt, 2);
    chk("sw_log_addr", log_addr, 32'h3000);
    tick();

    // SH flushed in second REQ cycle
    set_in(1, 3'b001, 32'h4002, 32'h1234CAFE, 0, 0, 0); tick();
    chk("shf_req1", data_req, 1);
    tick();
    set_in(1, 3'b001, 32'h4002, 32'h1234CAFE, 1, 0, 0); #1;
    chk("shf_flush_stall", st_stall, 0);
    tick();
    quiet(); #1;
    chk("shf_withdrawn", data_req, 0);
    tick();
    chk("shf_still_idle", data_req, 0);
    chk("shf_no_write", log_cnt, 2);

    // SH flushed while waiting: write still completes
    set_in(1, 3'b001, 32'h4002, 32'h1234CAFE, 0, 0, 0); tick();
    chk("shw_wstrb", data_wstrb, 4'b1100);
    chk("shw_wdata", data_wdata, 32'hCAFECAFE);
    set_in(1, 3'b001, 32'h4002, 32'h1234CAFE, 0, 1, 0); tick();
    set_in(1, 3'b001, 32'h4002, 32'h1234CAFE, 1, 0, 0); #1;
    chk("shw_flush_stall", st_stall, 1);
    tick();
    set_in(1, 3'b001, 32'h4002, 32'h1234CAFE, 1, 0, 1); #1;
    chk("shw_dok_stall", st_stall, 0);
    tick();
    quiet(); #1;
    chk("shw_log_cnt", log_cnt, 3);
    chk("shw_log_size", log_size, 1);

    // Flush coinciding with addr_ok, re-accepted right after returning to IDLE
    set_in(1, 3'b000, 32'h7001, 32'h00000077, 0, 0, 0); tick();
    set_in(1, 3'b000, 32'h7001, 32'h00000077, 1, 1, 0); #1;
    chk("fa_stall", st_stall, 1);
    tick();
    set_in(1, 3'b000, 32'h7001, 32'h00000077, 0, 0, 1); tick();
    chk("fa_log_wstrb", log_strb, 4'b0010);
    chk("fa_log_wdata", log_wdata, 32'h77777777);

    // Reset while waiting
    set_in(1, 3'b000, 32'h6000, 32'h00000011, 0, 0, 0); tick();
    set_in(1, 3'b000, 32'h6000, 32'h00000011, 0, 1, 0); tick();
    rst = 1'b1; quiet(); tick();
    rst = 1'b0; #1;
    chk("rstw_req", data_req, 0);
    chk("rstw_stall", st_stall, 0);
    tick();
    set_in(1, 3'b000, 32'h6002, 32'h0000005A, 0, 0, 0); #1;
    chk("rstw_sb_stall", st_stall, 1);
    tick();
    chk("rstw_sb_wstrb", data_wstrb, 4'b0100);
    chk("rstw_sb_wdata", data_wdata, 32'h5A5A5A5A);
    set_in(1, 3'b000, 32'h6002, 32'h0000005A, 0, 1, 1); tick();
    quiet(); tick();

    // Non-store opcode
    set_in(1, 3'b011, 32'h5000, 32'h0, 0, 0, 0); #1;
    chk("nonstore_stall", st_stall, 0);
    tick(); quiet(); tick();

`ifdef UNALIGNED_STORE_EN
    set_in(1, 3'b100, 32'h5001, 32'hAABBCCDD, 0, 0, 0); #1;
    chk("swl_stall", st_stall, 1);
    tick();
    chk("swl_addr", data_addr, 32'h5000);
    chk("swl_wstrb", data_wstrb, 4'b0011);
    chk("swl_wdata", data_wdata, 32'h0000AABB);
    chk("swl_size", data_size, 2);
    set_in(1, 3'b100, 32'h5001, 32'hAABBCCDD, 0, 1, 1); tick();
    chk("swl_log_wdata", log_wdata, 32'h0000AABB);
    set_in(1, 3'b101, 32'h5002, 32'hAABBCCDD, 0, 0, 0); tick();
    chk("swr_addr", data_addr, 32'h5000);
    chk("swr_wstrb", data_wstrb, 4'b1100);
    chk("swr_wdata", data_wdata, 32'hCCDD0000);
    set_in(1, 3'b101, 32'h5002, 32'hAABBCCDD, 0, 1, 1); tick();
    chk("swr_log_wdata", log_wdata, 32'hCCDD0000);
    quiet(); tick();
`else
    set_in(1, 3'b100, 32'h5001, 32'hAABBCCDD, 0, 0, 0); #1;
    chk("swl_off_stall", st_stall, 0);
    chk("swl_off_ades", st_ades, 0);
    tick();
    chk("swl_off_req", data_req, 0);
    set_in(1, 3'b101, 32'h5002, 32'hAABBCCDD, 0, 0, 0); #1;
    chk("swr_off_stall", st_stall, 0);
    tick();
    chk("swr_off_req", data_req, 0);
    quiet(); tick();
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
